// File: rtl/stretch_event_queue_sync2.sv
// sync2: generic two-flop synchronizer with a parameterised reset value.
module sync2 #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic d_i,
   output logic q_o
);
   logic [1:0] ff_q;
   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) ff_q <= {2{RST_VAL}};
      else         ff_q <= {ff_q[0], d_i};
   assign q_o = ff_q[1];
endmodule

// File: rtl/stretch_event_queue.sv
// stretch_event_queue: turns stretched pulses into counted valid/ready events with sticky overflow.
// STRETCH_EVENT_QUEUE_SYNC_EN inserts a two-flop synchronizer on in_i (+2 cycles latency).
module stretch_event_queue #(
   parameter int CNT_WIDTH = 4
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 in_i,
   output logic                 pulse_o,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic [CNT_WIDTH-1:0] pending_o,
   output logic                 overflow_o,
   input  logic                 clr_ovf_i
);
   logic                 in_s;
   logic                 in_d_q, in_q_q, pulse_q, ovf_q, ovf_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 rise, pop, full;
`ifdef STRETCH_EVENT_QUEUE_SYNC_EN
   sync2 #(.RST_VAL(1'b1)) u_sync (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .d_i     (in_i),
      .q_o     (in_s)
   );
`else
   assign in_s = in_i;
`endif
   assign rise = in_d_q & ~in_q_q;
   assign pop  = (cnt_q != '0) & ready_i;
   assign full = &cnt_q;
   // A push that coincides with a pop leaves the count unchanged, even when full.
   always_comb begin
      cnt_d = (rise & ~pop & ~full) ? cnt_q + CNT_WIDTH'(1) :
              (pop & ~rise)         ? cnt_q - CNT_WIDTH'(1) : cnt_q;
      ovf_d = (rise & full & ~pop) ? 1'b1 : clr_ovf_i ? 1'b0 : ovf_q;
   end
   // History flops reset high so a level already high at reset release is ignored.
   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) begin
         in_d_q  <= 1'b1;
         in_q_q  <= 1'b1;
         pulse_q <= 1'b0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         in_d_q  <= in_s;
         in_q_q  <= in_d_q;
         pulse_q <= rise;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   assign pulse_o    = pulse_q;
   assign valid_o    = cnt_q != '0;
   assign pending_o  = cnt_q;
   assign overflow_o = ovf_q;
endmodule

// File: tb/tb_stretch_event_queue.sv
// tb_stretch_event_queue: directed checks of reset, counting, handshake, overflow and async reset.
module tb_stretch_event_queue;
`ifdef STRETCH_EVENT_QUEUE_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif
   logic       clk = 1'b0, reset_i, in_i, ready_i, clr_ovf_i;
   logic       pulse_o, valid_o, overflow_o;
   logic [3:0] pending_o;
   int         n_chk = 0, n_err = 0, npulse = 0, p0;

   stretch_event_queue #(.CNT_WIDTH(4)) dut (
      .clk_i      (clk),
      .reset_i    (reset_i),
      .in_i       (in_i),
      .pulse_o    (pulse_o),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .pending_o  (pending_o),
      .overflow_o (overflow_o),
      .clr_ovf_i  (clr_ovf_i)
   );

   always #5 clk = ~clk;
   always @(posedge clk) if (pulse_o) npulse <= npulse + 1;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_event(input int h, input int l);
      in_i = 1'b1;
      cyc(h);
      in_i = 1'b0;
      cyc(l);
   endtask

   initial begin
      reset_i = 1'b1; in_i = 1'b1; ready_i = 1'b0; clr_ovf_i = 1'b0;
      #1;
      check("rst_pulse", pulse_o, 0);
      check("rst_valid", valid_o, 0);
      check("rst_pending", pending_o, 0);
      check("rst_ovf", overflow_o, 0);
      cyc(2);
      reset_i = 1'b0;
      p0 = npulse;
      cyc(10);
      check("high_at_reset_pulses", npulse - p0, 0);
      check("high_at_reset_pending", pending_o, 0);
      in_i = 1'b0;
      cyc(3);

      p0 = npulse;
      repeat (3) push_event(3, 3);
      check("three_pulses", npulse - p0, 3);
      check("three_pending", pending_o, 3);
      check("three_valid", valid_o, 1);
      ready_i = 1'b1;
      cyc(1); check("pop1", pending_o, 2);
      cyc(1); check("pop2", pending_o, 1); check("pop2_valid", valid_o, 1);
      cyc(1); check("pop3", pending_o, 0); check("pop3_valid", valid_o, 0);
      cyc(2); check("no_underflow", pending_o, 0);
      ready_i = 1'b0;

      p0 = npulse;
      repeat (15) push_event(2, 2);
      check("ovf_15_pending", pending_o, 15);
      check("ovf_15_flag", overflow_o, 0);
      push_event(2, 2);
      check("ovf_16_flag", overflow_o, 1);
      check("ovf_16_pending", pending_o, 15);
      push_event(2, 2);
      check("ovf_17_pending", pending_o, 15);
      check("ovf_pulses", npulse - p0, 17);
      clr_ovf_i = 1'b1;
      cyc(1);
      clr_ovf_i = 1'b0;
      check("clr_ovf_flag", overflow_o, 0);
      check("clr_ovf_pending", pending_o, 15);

      in_i = 1'b1;
      cyc(1 + LAT);
      ready_i = 1'b1;
      cyc(1);
      ready_i = 1'b0;
      check("simul_pulse", pulse_o, 1);
      check("simul_pending", pending_o, 15);
      check("simul_ovf", overflow_o, 0);
      in_i = 1'b0;
      cyc(3);
      ready_i = 1'b1;
      cyc(15);
      check("drain_pending", pending_o, 0);
      check("drain_valid", valid_o, 0);
      in_i = 1'b1;
      cyc(2 + LAT);
      check("empty_push", pending_o, 1);
      cyc(1);
      check("empty_pop", pending_o, 0);
      in_i = 1'b0;
      ready_i = 1'b0;
      cyc(3);

      repeat (16) push_event(2, 2);
      ready_i = 1'b1;
      cyc(10);
      ready_i = 1'b0;
      check("mid_pending", pending_o, 5);
      check("mid_ovf", overflow_o, 1);
      #1 reset_i = 1'b1;
      #1;
      check("async_pending", pending_o, 0);
      check("async_ovf", overflow_o, 0);
      check("async_valid", valid_o, 0);
      cyc(2);
      reset_i = 1'b0;
      cyc(3);
      check("post_reset_pending", pending_o, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/stretch_event_queue.md
# stretch_event_queue

Consumer-domain stage that sits directly downstream of `sync_stretch`. It turns each stretched pulse arriving on `in` into exactly one event. Each event is announced as a one-cycle strobe, counted in a saturating pending counter, and handed to a consumer through a valid/ready handshake, so no crossed event is lost or double-counted. An overflow flag records drops.

## Interface
- `CNT_WIDTH`, default 4: width of the pending-event counter; capacity is 2^CNT_WIDTH−1 events (15 at default).
- `clk` in, 1 bit: destination-domain clock; all logic is on its rising edge.
- `reset` in, 1 bit: asynchronous, active-high reset.
- `in` in, 1 bit: stretched level from `sync_stretch` `out`.
- `pulse` out, 1 bit: one-cycle strobe per detected rising edge of `in`.
- `valid` out, 1 bit: at least one event is pending.
- `ready` in, 1 bit: consumer accepts one event on a cycle where `valid && ready`.
- `pending` out, CNT_WIDTH bits: current count of undelivered events.
- `overflow` out, 1 bit: sticky; set when an event is dropped because the counter is full.
- `clr_ovf` in, 1 bit: synchronous clear of `overflow`.

## Operation
- **Input sampling:**
  - Sampled-input flop `in_d` takes `in` each clock (via the optional synchronizer, see Configuration).
  - History flop `in_q` takes `in_d`.
  - `rise = in_d & ~in_q`, combinational and internal only.
- **Strobe:** `pulse` is registered `rise`; it is high for exactly one cycle per rising edge, however long `in` stays high.
- **Pending counter**, updated on each clock:
  - `rise` and no pop: increment, if not full.
  - Pop (`valid && ready`) and no `rise`: decrement.
  - `rise` and pop together: unchanged.
  - `rise` while full and no pop: counter holds, `overflow` sets, and the event is dropped. `pulse` still fires.
  - `rise` while full with a simultaneous pop: counter holds, no overflow.
- **Handshake:**
  - `valid = (pending != 0)`, driven directly from the register.
  - `ready` asserted while `valid` is low has no effect; the counter never underflows.
  - `ready` may be held high continuously, giving one pop per cycle.
- **Overflow flag:**
  - `clr_ovf` clears `overflow` on the next edge.
  - If a drop and `clr_ovf` occur in the same cycle, set wins.

## Timing
- **Reset values:**
  - `pulse`=0, `valid`=0, `pending`=0, `overflow`=0.
  - `in_d`=1 and `in_q`=1, so an `in` that is already high when reset deasserts is not counted; `in` must go low, then high.
- **Latency, macro off:**
  - `in` high is first sampled at edge k.
  - `pulse`=1, `pending` incremented and `valid`=1 all become visible after edge k+1.
- **Latency, macro on:** add 2 cycles, so visibility is after edge k+3.
- **Pop:** with `ready` high at edge j while `valid`, `pending` decrements after edge j.
- **Back-to-back edges:** `in` low for one sampled cycle between highs produces two events.
- **Reset mid-operation:** all state returns to reset values immediately (asynchronous); pending events are discarded.

## Configuration
- `STRETCH_EVENT_QUEUE_SYNC_EN` defined:
  - A two-flop synchronizer, reset to 1, sits between `in` and `in_d`.
  - This is used when `in` is not already synchronized to `clk`.
  - Latency is +2 cycles.
- Macro undefined: `in` feeds `in_d` directly, and the caller guarantees `in` is synchronous to `clk`.
- Behaviour is otherwise identical.

## Structure
- No shared package is needed; `CNT_WIDTH` is the only constant and stays a module parameter.
- One sub-module, `sync2`: a generic two-flop synchronizer with a parameterised reset value. It is instantiated only under `STRETCH_EVENT_QUEUE_SYNC_EN` and is reusable elsewhere.
- The counter, edge detector and flag are inline in `stretch_event_queue`.

## Test plan
- **Reset with high input:** hold `in`=1 through reset release, then keep it high for 10 cycles → `pulse` never fires; `pending`=0.
- **Three single events:** three 3-cycle highs on `in` separated by 3 lows, `ready`=0 → three `pulse` strobes; `pending` reaches 3 and `valid`=1. Then `ready`=1 for 5 cycles → `pending` steps 3,2,1,0 and `valid` falls after the third pop.
- **Overflow:** 17 events with `ready`=0 and CNT_WIDTH=4 → `pending` saturates at 15 and `overflow`=1 after the 16th edge. Assert `clr_ovf` for one cycle → `overflow`=0 and `pending` stays 15.
- **Simultaneous push and pop:** `pending`=15, `ready`=1 and an edge in the same cycle → `pending` stays 15 and `overflow` stays 0. Edge at `pending`=0 with `ready`=1 → counter goes to 1, then back to 0 the next cycle.
- **Reset mid-queue:** assert `reset` with `pending`=5 and `overflow`=1 → both clear immediately, without waiting for a clock edge.
- **Synchronizer latency:** rebuild with `STRETCH_EVENT_QUEUE_SYNC_EN` and feed a pulse from a clock with a 1.4 ns period into a 2 ns `clk` → every event is counted, and `pulse` appears 2 cycles later than the macro-off build.
